avalon_pio_pulse: RTL and testbench
===================================

Name: avalon_pio_pulse

Overview:
Parametrised Avalon-MM slave PIO, the next generation of the single-bit start-signal PIO. It provides a WIDTH-bit output register with atomic set, clear and toggle, and self-timed output pulses of PULSE_CYCLES clocks. It also provides a synchronised input port with rising-edge capture and a maskable interrupt. It sits on the HPS/Nios lightweight bus, driving start/strobe lines into accelerator blocks and collecting their done flags.

Parameters:
WIDTH, 8, bit width of out_port, in_port and all register fields (1..32)
PULSE_CYCLES, 16, high time of a pulse in clk cycles (>=1)
RESET_VALUE, 0, reset value of the DATA register (WIDTH bits)

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
address  input  3  word address of register
chipselect  input  1  slave select
write_n  input  1  active-low write strobe
writedata  input  32  write data; bits above WIDTH ignored
readdata  output  32  read data; bits above WIDTH read 0
in_port  input  WIDTH  asynchronous status inputs
out_port  output  WIDTH  data_out | pulse_active
irq  output  1  |(edge_cap & irq_mask)

Behaviour:
- Write strobe: wr = chipselect & ~write_n. Every register updates on the clk edge where wr is high. No wait states.
- readdata is combinational from address with zero read latency. It is zero-extended to 32 bits and is independent of chipselect.
- Register map (word address):
  - 0 DATA: RW. A write loads data_out.
  - 1 IN: RO. Returns in_sync.
  - 2 IRQMASK: RW.
  - 3 EDGECAP: read returns edge_cap. Writing 1 to a bit clears it; writing 0 leaves it unchanged.
  - 4 OUTSET: WO. data_out <= data_out | wd. Reads 0.
  - 5 OUTCLR: WO. data_out <= data_out & ~wd. Reads 0.
  - 6 PULSE: a write starts a pulse on the bits set in wd. A read returns pulse_active.
  - 7 TOGGLE: WO. data_out <= data_out ^ wd. Reads 0.
- Reset (synchronous, reset=1 at a clk edge):
  - data_out=RESET_VALUE.
  - pulse_active=0, pulse_cnt=0.
  - irq_mask=0, edge_cap=0, both sync stages=0, in_prev=0.
  - Reset overrides any coincident write.
  - After reset: out_port=RESET_VALUE, irq=0.
- Input path:
  - 2-flop synchroniser gives in_sync, with 2 cycles of latency from in_port.
  - in_prev holds in_sync delayed by 1 cycle.
  - Rising edge = in_sync & ~in_prev. Each edge sets the matching edge_cap bit.
  - A bit that sees a new edge and a write-1-clear in the same cycle stays set (set wins).
- Pulse engine: one shared down-counter, width clog2(PULSE_CYCLES+1). Two states, IDLE (pulse_cnt==0) and ACTIVE.
  - PULSE write with wd[WIDTH-1:0] != 0:
    - pulse_active |= wd.
    - pulse_cnt <= PULSE_CYCLES.
    - Allowed in either state; a write in ACTIVE retriggers, and all active bits restart their full length.
  - PULSE write with wd==0: no effect.
  - ACTIVE with no PULSE write: pulse_cnt decrements each cycle.
  - Cycle where pulse_cnt goes 1->0: pulse_active <= 0 and the engine returns to IDLE.
  - Bits are high on out_port for exactly PULSE_CYCLES cycles, starting the cycle after the write edge.
  - pulse_active is ORed onto out_port. It does not modify data_out, so a bit already high in DATA stays high after the pulse ends.
- DATA/OUTSET/OUTCLR/TOGGLE writes are independent of the pulse engine. A write coinciding with pulse expiry updates data_out normally.
- irq is combinational from registered state. It is high while any masked edge_cap bit is set.
- Unused address/writedata bits have no side effects.

Test Plan:
- Reset with WIDTH=8, RESET_VALUE=8'hA5, then read address 0 -> readdata=32'h000000A5, out_port=8'hA5, irq=0. Assert reset during an active pulse -> out_port=8'hA5 the next cycle, and address 6 reads 0.
- Atomic ops from DATA=8'h0F:
  - Write 4:8'hF0 -> 8'hFF.
  - Write 5:8'h3C -> 8'hC3.
  - Write 7:8'hFF -> 8'h3C.
  - Reads of addresses 4, 5 and 7 return 0.
- Pulse with PULSE_CYCLES=16 and DATA=0: write 6:8'h01 -> out_port[0] high for exactly 16 cycles, then 0. Read 6 returns 8'h01 during the pulse and 0 after.
- Retrigger and zero write:
  - Write 6:8'h01, then at cycle 10 write 6:8'h02 -> both bits high until 16 cycles after the second write, then drop together.
  - Write 6:8'h00 in IDLE -> nothing changes.
- Edge capture and irq:
  - Write 2:8'h04, then drive in_port[2] 0->1 -> edge_cap[2]=1 three cycles later, irq=1.
  - in_port[1] edge with mask 0 -> edge_cap[1]=1, irq unaffected.
  - Write 3:8'h04 -> irq=0.
  - A new edge in the same cycle as the clear -> bit remains 1.
- Write-disable checks:
  - Write with chipselect=0 -> no register change.
  - Write with write_n=1 -> no register change.
  - Writes to addresses 1 and 3 with 0 bits -> no change.

Source files
------------

// File: rtl/avalon_pio_pulse_if.sv
// Avalon-MM slave bus bundle for avalon_pio_pulse.
// Signals:
//   address    - word address of the register (3 bits)
//   chipselect - slave select
//   write_n    - active-low write strobe
//   writedata  - 32-bit write data
//   readdata   - 32-bit read data (combinational from address)
// Modports: slave (the PIO), master (the bus driver / testbench).
interface avalon_pio_pulse_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );
endinterface

// File: rtl/avalon_pio_pulse.sv
// Avalon-MM PIO with atomic set/clear/toggle, self-timed output pulses,
// synchronised inputs with rising-edge capture and a maskable interrupt.
// Ports:
//   clk      - system clock, all logic on the rising edge
//   reset    - synchronous active-high reset
//   bus      - Avalon-MM slave bundle (address/chipselect/write_n/writedata/readdata)
//   in_port  - asynchronous status inputs (WIDTH bits)
//   out_port - data_out | pulse_active (WIDTH bits)
//   irq      - high while any masked edge-capture bit is set
// Register map: 0 DATA, 1 IN, 2 IRQMASK, 3 EDGECAP (W1C), 4 OUTSET,
//               5 OUTCLR, 6 PULSE, 7 TOGGLE.
module avalon_pio_pulse #(
  parameter int                 WIDTH        = 8,
  parameter int                 PULSE_CYCLES = 16,
  parameter logic [WIDTH-1:0]   RESET_VALUE  = {WIDTH{1'b0}}
) (
  input  logic                  clk,
  input  logic                  reset,
  avalon_pio_pulse_if.slave     bus,
  input  logic [WIDTH-1:0]      in_port,
  output logic [WIDTH-1:0]      out_port,
  output logic                  irq
);

  localparam int CNT_W = $clog2(PULSE_CYCLES + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } pulse_state_e;

  logic               wr_s;
  logic [WIDTH-1:0]   wd_s;
  logic               pulse_start_s;
  logic [WIDTH-1:0]   rise_s;
  logic [31:0]        rd_s;

  logic [WIDTH-1:0]   data_out_q,  data_out_d;
  logic [WIDTH-1:0]   irq_mask_q,  irq_mask_d;
  logic [WIDTH-1:0]   edge_cap_q,  edge_cap_d;
  logic [WIDTH-1:0]   sync1_q;
  logic [WIDTH-1:0]   in_sync_q;
  logic [WIDTH-1:0]   in_prev_q;
  logic [WIDTH-1:0]   pulse_act_q, pulse_act_d;
  logic [CNT_W-1:0]   pulse_cnt_q, pulse_cnt_d;
  pulse_state_e       state_q,     state_d;

  assign wr_s          = bus.chipselect & ~bus.write_n;
  assign wd_s          = bus.writedata[WIDTH-1:0];
  // A PULSE write whose low WIDTH bits are all zero is a no-op, not a retrigger.
  assign pulse_start_s = wr_s && (bus.address == 3'd6) && (wd_s != {WIDTH{1'b0}});
  assign rise_s        = in_sync_q & ~in_prev_q;

  generate
    if (WIDTH < 32) begin : g_unused_wd
      logic unused_wd_s;
      assign unused_wd_s = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  // Register-write decode for DATA, IRQMASK and the write-1-clear EDGECAP.
  always_comb begin
    data_out_d = data_out_q;
    irq_mask_d = irq_mask_q;
    edge_cap_d = edge_cap_q;
    if (wr_s) begin
      case (bus.address)
        3'd0:    data_out_d = wd_s;
        3'd2:    irq_mask_d = wd_s;
        3'd3:    edge_cap_d = edge_cap_q & ~wd_s;
        3'd4:    data_out_d = data_out_q | wd_s;
        3'd5:    data_out_d = data_out_q & ~wd_s;
        3'd7:    data_out_d = data_out_q ^ wd_s;
        default: data_out_d = data_out_q;
      endcase
    end else begin
      data_out_d = data_out_q;
    end
    // New edges are ORed in last so a coincident clear cannot drop them.
    edge_cap_d = edge_cap_d | rise_s;
  end

  // Pulse engine next state: one shared counter, any start restarts all active bits.
  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    pulse_act_d = pulse_act_q;
    case (state_q)
      IDLE: begin
        if (pulse_start_s) begin
          state_d     = ACTIVE;
          pulse_cnt_d = CNT_W'(PULSE_CYCLES);
          pulse_act_d = pulse_act_q | wd_s;
        end else begin
          state_d     = IDLE;
        end
      end
      ACTIVE: begin
        if (pulse_start_s) begin
          pulse_cnt_d = CNT_W'(PULSE_CYCLES);
          pulse_act_d = pulse_act_q | wd_s;
        end else if (pulse_cnt_q == CNT_W'(1)) begin
          state_d     = IDLE;
          pulse_cnt_d = {CNT_W{1'b0}};
          pulse_act_d = {WIDTH{1'b0}};
        end else begin
          pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d     = IDLE;
        pulse_cnt_d = {CNT_W{1'b0}};
        pulse_act_d = {WIDTH{1'b0}};
      end
    endcase
  end

  // State registers; reset wins over any coincident write.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_out_q  <= RESET_VALUE;
      irq_mask_q  <= {WIDTH{1'b0}};
      edge_cap_q  <= {WIDTH{1'b0}};
      sync1_q     <= {WIDTH{1'b0}};
      in_sync_q   <= {WIDTH{1'b0}};
      in_prev_q   <= {WIDTH{1'b0}};
      pulse_act_q <= {WIDTH{1'b0}};
      pulse_cnt_q <= {CNT_W{1'b0}};
      state_q     <= IDLE;
    end else begin
      data_out_q  <= data_out_d;
      irq_mask_q  <= irq_mask_d;
      edge_cap_q  <= edge_cap_d;
      sync1_q     <= in_port;
      in_sync_q   <= sync1_q;
      in_prev_q   <= in_sync_q;
      pulse_act_q <= pulse_act_d;
      pulse_cnt_q <= pulse_cnt_d;
      state_q     <= state_d;
    end
  end

  // Zero-latency read mux, zero-extended, independent of chipselect.
  always_comb begin
    rd_s = 32'd0;
    case (bus.address)
      3'd0:    rd_s[WIDTH-1:0] = data_out_q;
      3'd1:    rd_s[WIDTH-1:0] = in_sync_q;
      3'd2:    rd_s[WIDTH-1:0] = irq_mask_q;
      3'd3:    rd_s[WIDTH-1:0] = edge_cap_q;
      3'd6:    rd_s[WIDTH-1:0] = pulse_act_q;
      default: rd_s = 32'd0;
    endcase
  end

  assign bus.readdata = rd_s;
  assign out_port     = data_out_q | pulse_act_q;
  assign irq          = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_avalon_pio_pulse.sv
module tb_avalon_pio_pulse;
  localparam int         W   = 8;
  localparam int         PC  = 16;
  localparam logic [7:0] RV  = 8'hA5;
  localparam int         MAXC = 4096;

  logic       clk;
  logic       reset;
  logic [7:0] in_port;
  logic [7:0] out_port;
  logic       irq;

  avalon_pio_pulse_if bus ();

  avalon_pio_pulse #(.WIDTH(W), .PULSE_CYCLES(PC), .RESET_VALUE(RV)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus.slave),
    .in_port  (in_port),
    .out_port (out_port),
    .irq      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Behavioural model: registers as plain values, pulses as an end time,
  // the synchroniser as a history of sampled inputs.
  int         k = -1;
  logic [7:0] m_data = 8'h00;
  logic [7:0] m_mask = 8'h00;
  logic [7:0] m_cap  = 8'h00;
  logic [7:0] m_pbits = 8'h00;
  int         m_pend = 0;
  logic [7:0] samp [0:MAXC-1];
  logic [7:0] cur_in = 8'h00;

  function automatic logic [7:0] s(input int i);
    return (i < 0) ? 8'h00 : samp[i];
  endfunction

  function automatic logic [7:0] m_pulse();
    return (k < m_pend) ? m_pbits : 8'h00;
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'd0, m_data};
      3'd1:    return {24'd0, s(k - 1)};
      3'd2:    return {24'd0, m_mask};
      3'd3:    return {24'd0, m_cap};
      3'd6:    return {24'd0, m_pulse()};
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_update(input logic rst, input logic cs, input logic wn,
                          input logic [2:0] a, input logic [31:0] wd, input logic [7:0] inp);
    logic [7:0] rise;
    logic [7:0] w8;
    logic       wr;
    rise = s(k - 2) & ~s(k - 3);
    w8   = wd[7:0];
    wr   = cs & ~wn;
    if (rst) begin
      m_data = RV; m_mask = 8'h00; m_cap = 8'h00; m_pbits = 8'h00; m_pend = 0;
      samp[k] = 8'h00;
      if (k >= 1) samp[k-1] = 8'h00;
      if (k >= 2) samp[k-2] = 8'h00;
    end else begin
      samp[k] = inp;
      if (wr) begin
        case (a)
          3'd0: m_data = w8;
          3'd2: m_mask = w8;
          3'd3: m_cap  = m_cap & ~w8;
          3'd4: m_data = m_data | w8;
          3'd5: m_data = m_data & ~w8;
          3'd7: m_data = m_data ^ w8;
          3'd6: if (w8 != 8'h00) begin
                  if (!(k - 1 < m_pend)) m_pbits = 8'h00;
                  m_pbits = m_pbits | w8;
                  m_pend  = k + PC;
                end
          default: ;
        endcase
      end
      m_cap = m_cap | rise;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic cs, input logic wn,
                      input logic [2:0] a, input logic [31:0] wd, input logic [7:0] inp);
    reset          = rst;
    bus.chipselect = cs;
    bus.write_n    = wn;
    bus.address    = a;
    bus.writedata  = wd;
    in_port        = inp;
    @(posedge clk);
    k++;
    m_update(rst, cs, wn, a, wd, inp);
    #1;
    chk("model_out_port", {24'd0, out_port}, {24'd0, m_data | m_pulse()});
    chk("model_irq", {31'd0, irq}, {31'd0, |(m_cap & m_mask)});
    chk("model_readdata", bus.readdata, m_read(a));
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] wd);
    step(1'b0, 1'b1, 1'b0, a, wd, cur_in);
  endtask

  task automatic rd(input logic [2:0] a);
    step(1'b0, 1'b1, 1'b1, a, 32'd0, cur_in);
  endtask

  initial begin
    int hi;
    int both;
    logic rr;
    reset = 1'b1; bus.chipselect = 1'b0; bus.write_n = 1'b1;
    bus.address = 3'd0; bus.writedata = 32'd0; in_port = 8'h00;

    // Reset state
    step(1'b1, 1'b0, 1'b1, 3'd0, 32'd0, 8'h00);
    step(1'b1, 1'b1, 1'b0, 3'd0, 32'h0000_00FF, 8'h00);
    chk("reset_out", {24'd0, out_port}, 32'h0000_00A5);
    chk("reset_irq", {31'd0, irq}, 32'd0);
    rd(3'd0);
    chk("reset_read0", bus.readdata, 32'h0000_00A5);

    // Atomic set / clear / toggle
    wr(3'd0, 32'h0000_000F);
    wr(3'd4, 32'h0000_00F0); chk("outset", {24'd0, out_port}, 32'h0000_00FF);
    wr(3'd5, 32'h0000_003C); chk("outclr", {24'd0, out_port}, 32'h0000_00C3);
    wr(3'd7, 32'h0000_00FF); chk("toggle", {24'd0, out_port}, 32'h0000_003C);
    rd(3'd4); chk("read4", bus.readdata, 32'd0);
    rd(3'd5); chk("read5", bus.readdata, 32'd0);
    rd(3'd7); chk("read7", bus.readdata, 32'd0);

    // Single pulse length
    wr(3'd0, 32'd0);
    wr(3'd6, 32'h0000_0001);
    chk("pulse_rd_during", bus.readdata, 32'h0000_0001);
    hi = (out_port[0] === 1'b1) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      rd(3'd6);
      if (out_port[0] === 1'b1) hi++;
    end
    chk("pulse_len", hi, 32'd16);
    chk("pulse_rd_after", bus.readdata, 32'd0);

    // Retrigger at cycle 10
    wr(3'd6, 32'h0000_0001);
    for (int i = 0; i < 9; i++) rd(3'd6);
    wr(3'd6, 32'h0000_0002);
    both = (out_port === 8'h03) ? 1 : 0;
    for (int i = 0; i < 20; i++) begin
      rd(3'd6);
      if (out_port === 8'h03) both++;
    end
    chk("retrig_len", both, 32'd16);
    chk("retrig_drop", {24'd0, out_port}, 32'd0);

    // Zero PULSE write in IDLE
    wr(3'd6, 32'd0);
    chk("pulse_zero_out", {24'd0, out_port}, 32'd0);
    chk("pulse_zero_rd", bus.readdata, 32'd0);

    // Edge capture and irq
    wr(3'd2, 32'h0000_0004);
    cur_in = 8'h04;
    rd(3'd3); rd(3'd3);
    chk("edge_not_yet_irq", {31'd0, irq}, 32'd0);
    rd(3'd3);
    chk("edge2_cap", bus.readdata, 32'h0000_0004);
    chk("edge2_irq", {31'd0, irq}, 32'd1);
    cur_in = 8'h06;
    rd(3'd3); rd(3'd3); rd(3'd3);
    chk("edge1_cap", bus.readdata, 32'h0000_0006);
    wr(3'd3, 32'h0000_0004);
    chk("w1c_cap", bus.readdata, 32'h0000_0002);
    chk("w1c_irq", {31'd0, irq}, 32'd0);
    cur_in = 8'h00;
    rd(3'd0); rd(3'd0); rd(3'd0);
    wr(3'd3, 32'h0000_00FF);
    chk("cap_cleared", bus.readdata, 32'd0);
    cur_in = 8'h04;
    rd(3'd0); rd(3'd0);
    wr(3'd3, 32'h0000_0004);
    chk("set_wins_cap", bus.readdata, 32'h0000_0004);
    chk("set_wins_irq", {31'd0, irq}, 32'd1);

    // Write-disable checks
    step(1'b0, 1'b0, 1'b0, 3'd0, 32'h0000_00FF, cur_in);
    chk("no_cs", {24'd0, out_port}, 32'd0);
    step(1'b0, 1'b1, 1'b1, 3'd0, 32'h0000_00FF, cur_in);
    chk("no_wn", {24'd0, out_port}, 32'd0);
    wr(3'd1, 32'h0000_00FF);
    chk("wr_in_ro", {24'd0, out_port}, 32'd0);
    wr(3'd3, 32'd0);
    chk("wr_cap_zero", bus.readdata, 32'h0000_0004);

    // Reset during an active pulse
    wr(3'd6, 32'h0000_00FF);
    chk("pulse_all", {24'd0, out_port}, 32'h0000_00FF);
    step(1'b1, 1'b1, 1'b1, 3'd6, 32'd0, cur_in);
    chk("rst_pulse_out", {24'd0, out_port}, 32'h0000_00A5);
    chk("rst_pulse_rd6", bus.readdata, 32'd0);
    rd(3'd6);
    chk("rst_pulse_rd6_after", bus.readdata, 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      rr = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 7) == 0) cur_in = 8'($urandom_range(0, 255));
      step(rr, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           3'($urandom_range(0, 7)), $urandom, cur_in);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
